audio_adc_rx: RTL and testbench

- Capture-side counterpart of the DAC audio controller: receives I2S serial audio from the codec ADC (codec is bit-clock/LR-clock master) and deserialises it into 32-bit stereo words {left, right}.
- Words are buffered in a small FIFO for the core, which reads them with a read strobe.
- Sits in the top level beside the DAC controller; it shares the codec's BCLK and uses AUD_ADCLRCK and AUD_ADCDAT.

---
 rtl/audio_adc_rx.sv | 171 +++++++++++++++++
 tb/tb_audio_adc_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// rtl/audio_adc_rx.sv - I2S ADC capture: deserialises stereo frames into a show-ahead FIFO
module audio_adc_rx #(
    parameter int WIDTH       = 16,
    parameter int FIFO_AW     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 m_clock,
    input  logic                 p_reset,
    input  logic                 iAUD_BCK,
    input  logic                 iAUD_ADCLRCK,
    input  logic                 iAUD_ADCDAT,
    output logic [2*WIDTH-1:0]   oDATA,
    output logic                 oDATA_VALID,
    input  logic                 iDATA_RD,
    output logic [FIFO_AW:0]     oLEVEL,
    output logic                 oOVERFLOW,
    output logic                 oFRAME_ERR,
    input  logic                 iCLR
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNTW  = FIFO_AW + 1;
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, WAIT} state_t;

    logic [SYNC_STAGES-1:0] bck_sync, lrck_sync, dat_sync;
    logic                   bck_s, lrck_s, dat_s;
    logic                   bck_prev, lrck_prev;
    logic                   brise, lr_rise, lr_fall, lr_edge;

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            bck_sync  <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bck_prev  <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bck_sync  <= {bck_sync[SYNC_STAGES-2:0], iAUD_BCK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], iAUD_ADCLRCK};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], iAUD_ADCDAT};
            bck_prev  <= bck_s;
            if (brise)
                lrck_prev <= lrck_s;
        end
    end

    assign bck_s   = bck_sync[SYNC_STAGES-1];
    assign lrck_s  = lrck_sync[SYNC_STAGES-1];
    assign dat_s   = dat_sync[SYNC_STAGES-1];
    assign brise   = bck_s & ~bck_prev;
    // LRCK is only judged on bit-clock rises, so glitches between bits never count as edges
    assign lr_rise = brise & lrck_s & ~lrck_prev;
    assign lr_fall = brise & ~lrck_s & lrck_prev;
    assign lr_edge = lr_rise | lr_fall;

    state_t               state;
    logic                 chan;
    logic                 left_valid;
    logic                 push_req;
    logic                 frame_err;
    logic                 ferr_set;
    logic [CW-1:0]        bitcnt;
    logic [WIDTH-2:0]     shreg;
    logic [WIDTH-1:0]     left;
    logic [WIDTH-1:0]     sample;
    logic [2*WIDTH-1:0]   push_data;

    assign sample   = {shreg, dat_s};
    assign ferr_set = brise & lr_edge & ((state == DELAY) | (state == SHIFT));

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state      <= IDLE;
            chan       <= 1'b0;
            bitcnt     <= '0;
            shreg      <= '0;
            left       <= '0;
            left_valid <= 1'b0;
            push_req   <= 1'b0;
            push_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            frame_err <= ferr_set | (frame_err & ~iCLR);
            if (brise) begin
                case (state)
                    IDLE: begin
                        if (lr_fall) begin
                            state <= DELAY;
                            chan  <= 1'b0;
                        end
                    end
                    DELAY, SHIFT: begin
                        if (lr_edge) begin
                            left_valid <= 1'b0;
                            chan       <= lr_rise;
                            state      <= DELAY;
                        end else if (state == DELAY) begin
                            bitcnt <= '0;
                            state  <= SHIFT;
                        end else begin
                            shreg  <= sample[WIDTH-2:0];
                            bitcnt <= bitcnt + CW'(1);
                            if (bitcnt == LAST) begin
                                state <= WAIT;
                                if (!chan) begin
                                    left       <= sample;
                                    left_valid <= 1'b1;
                                end else if (left_valid) begin
                                    push_req   <= 1'b1;
                                    push_data  <= {left, sample};
                                    left_valid <= 1'b0;
                                end
                            end
                        end
                    end
                    WAIT: begin
                        if (lr_edge) begin
                            state <= DELAY;
                            chan  <= lr_rise;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [CNTW-1:0]    count;
    logic               overflow;
    logic               pop, full, wr;

    assign pop  = iDATA_RD & (count != '0);
    assign full = (count == CNTW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word
    assign wr   = push_req & (~full | pop);

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + FIFO_AW'(1);
            end
            if (pop)
                rptr <= rptr + FIFO_AW'(1);
            case ({wr, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
            overflow <= (push_req & full & ~pop) | (overflow & ~iCLR);
        end
    end

    assign oDATA       = mem[rptr];
    assign oDATA_VALID = (count != '0);
    assign oLEVEL      = count;
    assign oOVERFLOW   = overflow;
    assign oFRAME_ERR  = frame_err;
endmodule

// File: tb/tb_audio_adc_rx.sv
// tb/tb_audio_adc_rx.sv - randomized scoreboard bench for audio_adc_rx
module tb_audio_adc_rx;
    localparam int W     = 16;
    localparam int AW    = 2;
    localparam int SS    = 2;
    localparam int DEPTH = 4;
    localparam int HB    = 10;

    logic clk = 0, rst = 1, bck = 0, lrck = 0, dat = 0;
    logic rd_mon = 0, rd_main = 0, clr = 0;
    logic [2*W-1:0] data;
    logic           valid, ovf, ferr;
    logic [AW:0]    level;

    audio_adc_rx #(.WIDTH(W), .FIFO_AW(AW), .SYNC_STAGES(SS)) dut (
        .m_clock(clk), .p_reset(rst), .iAUD_BCK(bck), .iAUD_ADCLRCK(lrck),
        .iAUD_ADCDAT(dat), .oDATA(data), .oDATA_VALID(valid),
        .iDATA_RD(rd_mon | rd_main), .oLEVEL(level), .oOVERFLOW(ovf),
        .oFRAME_ERR(ferr), .iCLR(clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0;
    logic [2*W-1:0] exp_q[$];
    int   m_level = 0;
    bit   m_ovf = 0, m_ferr = 0, m_prev_lr = 0, m_armed = 0, m_short = 0, m_have_left = 0;
    logic [W-1:0] m_left = '0;
    bit   drain = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_level = 0; m_ovf = 0; m_ferr = 0;
        m_prev_lr = 0; m_armed = 0; m_short = 0; m_have_left = 0;
    endtask

    task automatic model_push(input logic [2*W-1:0] w);
        if (m_level < DEPTH) begin
            exp_q.push_back(w);
            m_level++;
        end else
            m_ovf = 1;
    endtask

    // Half-frame level view: a half is usable only if it lasts the edge bit, the delay bit and W data bits
    task automatic model_half(input bit lr, input int nbck, input logic [W-1:0] d);
        bit is_edge;
        is_edge = (lr != m_prev_lr);
        m_prev_lr = lr;
        if (!is_edge) return;
        if (!m_armed) begin
            if (lr) return;
            m_armed = 1;
            m_short = 0;
        end
        if (m_short) begin
            m_ferr = 1;
            m_have_left = 0;
        end
        m_short = (nbck < W + 2);
        if (m_short) return;
        if (!lr) begin
            m_left = d;
            m_have_left = 1;
        end else if (m_have_left) begin
            m_have_left = 0;
            model_push({m_left, d});
        end
    endtask

    task automatic pop_model();
        if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL fullpop_head: actual=%0h required=<model empty>", data);
        end else begin
            check("fullpop_head", data, exp_q[0]);
            void'(exp_q.pop_front());
            m_level--;
        end
    endtask

    task automatic check_zero_outputs();
        check("rst_level", level, 0);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ferr", ferr, 0);
    endtask

    // mode: 0 normal, 1 no model (reset held), 2 reset pulse at bit 5, 3 pop in the push cycle
    task automatic send_half(input bit lr, input int nbck, input logic [W-1:0] d, input int mode);
        for (int k = 0; k < nbck; k++) begin
            @(negedge clk);
            bck  = 0;
            lrck = lr;
            dat  = (k >= 2 && k < W + 2) ? d[W+1-k] : 1'($urandom);
            repeat (HB) @(negedge clk);
            bck = 1;
            if (k == W + 1 || (k == nbck - 1 && nbck < W + 2)) begin
                if (mode == 3) pop_model();
                if (mode == 0 || mode == 3) model_half(lr, nbck, d);
            end
            if (mode == 3 && k == W + 1) begin
                repeat (SS + 1) @(posedge clk);
                @(negedge clk);
                rd_main = 1;
                @(negedge clk);
                rd_main = 0;
                repeat (HB - SS - 3) @(negedge clk);
            end else if (mode == 2 && k == 5) begin
                rst = 1;
                #1;
                check_zero_outputs();
                model_reset();
                repeat (3) @(negedge clk);
                rst = 0;
                repeat (HB - 4) @(negedge clk);
            end else
                repeat (HB - 1) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        send_half(0, 32, l, 0);
        send_half(1, 32, r, 0);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", (t < 3000), 1);
        check("level_empty", level, 0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        m_ovf = 0;
        m_ferr = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (drain && valid && !rst) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL fifo_unexpected: actual=%0h required=<no word>", data);
                end else begin
                    check("fifo_data", data, exp_q.pop_front());
                    m_level--;
                end
                rd_mon = 1;
                @(negedge clk);
                rd_mon = 0;
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        check_zero_outputs();

        send_half(1, 12, '0, 1);
        rst = 0;
        send_half(1, 20, 16'($urandom), 0);
        send_frame(16'hA5C3, 16'h1234);
        repeat (10) @(negedge clk);
        check("basic_level", level, 1);
        check("basic_valid", valid, 1);
        check("basic_data", data, 32'hA5C31234);
        drain = 1;
        wait_drain();
        drain = 0;

        for (int k = 0; k < 5; k++)
            send_frame(16'(2 * k + 1), 16'(2 * k + 2));
        repeat (10) @(negedge clk);
        check("ovf_level", level, m_level);
        check("ovf_level_full", level, DEPTH);
        check("ovf_flag", ovf, m_ovf);
        check("ovf_head", data, 32'h00010002);
        pulse_clr();
        check("ovf_clr", ovf, 0);

        send_half(0, 32, 16'h00BB, 0);
        send_half(1, 32, 16'h00CC, 3);
        repeat (10) @(negedge clk);
        check("fullpop_level", level, DEPTH);
        check("fullpop_ovf", ovf, m_ovf);
        check("fullpop_tail", exp_q[DEPTH-1], 32'h00BB00CC);
        drain = 1;
        wait_drain();

        send_half(0, 8, 16'($urandom), 0);
        send_half(1, 32, 16'($urandom), 0);
        send_frame(16'h5A5A, 16'hC3C3);
        wait_drain();
        check("short_ferr", ferr, m_ferr);
        check("short_ferr_set", ferr, 1);
        pulse_clr();
        check("ferr_clr", ferr, 0);

        drain = 0;
        send_frame(16'($urandom), 16'($urandom));
        repeat (10) @(negedge clk);
        check("prerst_level", level, m_level);
        send_half(0, 32, 16'($urandom), 2);
        send_half(1, 32, 16'($urandom), 0);
        send_frame(16'h8001, 16'h7FFE);
        repeat (10) @(negedge clk);
        check("postrst_level", level, 1);
        check("postrst_data", data, 32'h80017FFE);
        drain = 1;
        wait_drain();

        for (int i = 0; i < 20; i++) begin
            for (int lr = 0; lr < 2; lr++) begin
                int nb;
                nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, W + 1) : $urandom_range(W + 2, 32);
                send_half(lr[0], nb, 16'($urandom), 0);
            end
        end
        wait_drain();
        check("rand_ferr", ferr, m_ferr);
        check("rand_ovf", ovf, m_ovf);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
